// File: rtl/game_pkg.sv
// Shared types and constants for the game state controller.
// Optional feature macro: GAME_PAUSE_EN adds the PAUSED state.
package game_pkg;

  typedef enum logic [2:0] {
    ST_WELCOME   = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT_PAUSE = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_WIN       = 3'd4
`ifdef GAME_PAUSE_EN
    , ST_PAUSED  = 3'd5
`endif
  } state_t;

  // Background drawer encodings
  localparam logic [1:0] BG_WELCOME  = 2'b00;
  localparam logic [1:0] BG_PLAY     = 2'b01;
  localparam logic [1:0] BG_GAMEOVER = 2'b10;
  localparam logic [1:0] BG_WIN      = 2'b11;

  // Default parameter values
  localparam int LIVES_INIT_DEF      = 3;
  localparam int NUM_LEVELS_DEF      = 4;
  localparam int HIT_HOLD_FRAMES_DEF = 60;
  localparam int END_FRAMES_DEF      = 180;

  // Background selection for a given state; PAUSED and HIT_PAUSE keep the play field
  function automatic logic [1:0] bg_of(input state_t s);
    logic [1:0] bg;
    bg = BG_WELCOME;
    case (s)
      ST_WELCOME:   bg = BG_WELCOME;
      ST_PLAY:      bg = BG_PLAY;
      ST_HIT_PAUSE: bg = BG_PLAY;
      ST_GAME_OVER: bg = BG_GAMEOVER;
      ST_WIN:       bg = BG_WIN;
`ifdef GAME_PAUSE_EN
      ST_PAUSED:    bg = BG_PLAY;
`endif
      default:      bg = BG_WELCOME;
    endcase
    return bg;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchronizer for an asynchronous key level, followed by a
// one-clock rising-edge pulse.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the key and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: welcome / play / hit pause / game over / win,
// tracking lives and level. Define GAME_PAUSE_EN to add keyPause/paused
// and a PAUSED state reachable only from PLAY.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT      = LIVES_INIT_DEF,
  parameter int NUM_LEVELS      = NUM_LEVELS_DEF,
  parameter int HIT_HOLD_FRAMES = HIT_HOLD_FRAMES_DEF,
  parameter int END_FRAMES      = END_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       keyStart,
  input  logic       playerHit,
  input  logic       levelCleared,
  output logic [1:0] bgState,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       newLevel,
  output logic       inPlay
`ifdef GAME_PAUSE_EN
  ,
  input  logic       keyPause,
  output logic       paused
`endif
);

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [8:0] HIT_TARGET = 9'(HIT_HOLD_FRAMES);
  localparam logic [8:0] END_TARGET = 9'(END_FRAMES);

  state_t     r_state;
  logic [1:0] r_lives;
  logic [2:0] r_level;
  logic       r_new_level;
  logic [1:0] r_bg;
  logic       r_in_play;
  logic [7:0] r_frame_cnt;

  state_t     w_state_next;
  logic [1:0] w_lives_next;
  logic [2:0] w_level_next;
  logic       w_new_level_next;
  logic [7:0] w_cnt_next;
  logic [8:0] w_cnt_inc;
  logic       w_hit_done;
  logic       w_end_done;
  logic       w_start_rise;

  key_edge_detect u_start_key (
    .clk    (clk),
    .reset  (reset),
    .i_key  (keyStart),
    .o_rise (w_start_rise)
  );

`ifdef GAME_PAUSE_EN
  logic w_pause_rise;
  logic r_paused;

  key_edge_detect u_pause_key (
    .clk    (clk),
    .reset  (reset),
    .i_key  (keyPause),
    .o_rise (w_pause_rise)
  );
`endif

  // Frame count including the current pulse, widened so the compare cannot wrap
  assign w_cnt_inc  = {1'b0, r_frame_cnt} + 9'd1;
  assign w_hit_done = startOfFrame && (w_cnt_inc >= HIT_TARGET);
  assign w_end_done = startOfFrame && (w_cnt_inc >= END_TARGET);

  // Next-state, lives/level updates and saturating frame counter
  always_comb begin
    w_state_next     = r_state;
    w_lives_next     = r_lives;
    w_level_next     = r_level;
    w_new_level_next = 1'b0;
    w_cnt_next       = r_frame_cnt;
    if (startOfFrame && (r_frame_cnt != 8'hFF)) begin
      w_cnt_next = r_frame_cnt + 8'd1;
    end

    case (r_state)
      ST_WELCOME: begin
        if (w_start_rise) begin
          w_state_next     = ST_PLAY;
          w_lives_next     = LIVES_LOAD;
          w_level_next     = '0;
          w_new_level_next = 1'b1;
        end
      end

      ST_PLAY: begin
`ifdef GAME_PAUSE_EN
        if (w_pause_rise) begin
          w_state_next = ST_PAUSED;
        end else
`endif
        if (playerHit) begin
          // A hit wins over a simultaneous level clear; the clear is lost
          if (r_lives <= 2'd1) begin
            w_lives_next = '0;
            w_state_next = ST_GAME_OVER;
          end else begin
            w_lives_next = r_lives - 2'd1;
            w_state_next = ST_HIT_PAUSE;
          end
        end else if (levelCleared) begin
          if (r_level >= LAST_LEVEL) begin
            w_state_next = ST_WIN;
          end else begin
            w_level_next     = r_level + 3'd1;
            w_new_level_next = 1'b1;
          end
        end
      end

      ST_HIT_PAUSE: begin
        if (w_hit_done) begin
          w_state_next = ST_PLAY;
        end
      end

      ST_GAME_OVER, ST_WIN: begin
        if (w_start_rise || w_end_done) begin
          w_state_next = ST_WELCOME;
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (w_pause_rise) begin
          w_state_next = ST_PLAY;
        end
      end
`endif

      default: begin
        w_state_next = ST_WELCOME;
      end
    endcase

    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end
  end

  // State register with registered outputs derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_WELCOME;
      r_lives     <= '0;
      r_level     <= '0;
      r_new_level <= 1'b0;
      r_bg        <= BG_WELCOME;
      r_in_play   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_lives     <= w_lives_next;
      r_level     <= w_level_next;
      r_new_level <= w_new_level_next;
      r_bg        <= bg_of(w_state_next);
      r_in_play   <= (w_state_next == ST_PLAY);
      r_frame_cnt <= w_cnt_next;
    end
  end

`ifdef GAME_PAUSE_EN
  // Registered pause indicator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paused <= 1'b0;
    end else begin
      r_paused <= (w_state_next == ST_PAUSED);
    end
  end

  assign paused = r_paused;
`endif

  assign bgState  = r_bg;
  assign lives    = r_lives;
  assign level    = r_level;
  assign newLevel = r_new_level;
  assign inPlay   = r_in_play;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL provide parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 SHALL provide parameter NUM_LEVELS, default 4, number of levels (1..8).
REQ-003 SHALL provide parameter HIT_HOLD_FRAMES, default 60, frames frozen after a hit.
REQ-004 SHALL provide parameter END_FRAMES, default 180, frames shown on the end screen before auto-return.
REQ-005 SHALL have port clk, input, 1, single system clock; every flop on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port startOfFrame, input, 1, one-clk pulse per video frame.
REQ-008 SHALL have port keyStart, input, 1, raw start key level, asynchronous to clk.
REQ-009 SHALL have port playerHit, input, 1, one-clk pulse on player/ball collision.
REQ-010 SHALL have port levelCleared, input, 1, one-clk pulse when the last ball is popped.
REQ-011 SHALL have port bgState, output, 2, 00 welcome, 01 play, 10 game over, 11 win; consumed by the background drawer.
REQ-012 SHALL have port lives, output, 2, remaining lives.
REQ-013 SHALL have port level, output, 3, current level index, zero-based.
REQ-014 SHALL have port newLevel, output, 1, one-clk pulse when a level starts.
REQ-015 SHALL have port inPlay, output, 1, high only in PLAY; gates ball and player motion.

Function
REQ-016 SHALL synchronize keyStart through two flops and rising-edge detect it; the resulting state change SHALL occur on the 3rd clk edge after keyStart is first sampled high.
REQ-017 SHALL implement the states WELCOME, PLAY, HIT_PAUSE, GAME_OVER and WIN; bgState SHALL be 00, 01, 01, 10 and 11 respectively, registered.
REQ-018 In WELCOME, a start edge SHALL go to PLAY, load lives=LIVES_INIT and level=0, and pulse newLevel in the same cycle.
REQ-019 In PLAY, playerHit SHALL decrement lives; if lives was 1, next state GAME_OVER with lives=0, else HIT_PAUSE.
REQ-020 In PLAY, levelCleared SHALL go to WIN if level==NUM_LEVELS-1, otherwise increment level, pulse newLevel and stay in PLAY.
REQ-021 If playerHit and levelCleared are high in the same cycle, playerHit SHALL take priority and levelCleared SHALL be dropped.
REQ-022 HIT_PAUSE SHALL count HIT_HOLD_FRAMES startOfFrame pulses, then return to PLAY; playerHit and levelCleared SHALL be ignored during the pause.
REQ-023 GAME_OVER and WIN SHALL go to WELCOME after END_FRAMES startOfFrame pulses or on a start edge, whichever comes first.
REQ-024 The frame counter SHALL clear on every state entry, be 8 bits wide, and never wrap.
REQ-025 Start edges in PLAY and HIT_PAUSE SHALL be ignored.

Reset
REQ-026 While reset is high: state=WELCOME, bgState=00, lives=0, level=0, newLevel=0, inPlay=0, counters and sync flops cleared.
REQ-027 Reset asserted mid-game SHALL abort immediately to WELCOME, with no newLevel pulse on release.

Configuration
REQ-028 With GAME_PAUSE_EN defined, SHALL add input keyPause and output paused; a synchronized keyPause edge SHALL toggle PAUSED (bgState 01, inPlay 0) to and from PLAY only, with game events ignored while paused.
REQ-029 Without GAME_PAUSE_EN, keyPause and paused SHALL be absent and the PAUSED state SHALL not exist.

Structure
REQ-030 Package game_pkg SHALL hold the state enum, the bgState encodings (BG_WELCOME, BG_PLAY, BG_GAMEOVER, BG_WIN) and the default parameter constants.
REQ-031 Sub-module key_edge_detect (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once per key input.

Verification
REQ-032 Bench SHALL cover: reset release, then keyStart high for 10 clks -> exactly one transition to PLAY 3 clks later, lives=3, level=0, one newLevel pulse.
REQ-033 Bench SHALL cover: three playerHit pulses in PLAY, each followed by 60 frames -> lives 2, 1, 0, with bgState=10 after the third hit.
REQ-034 Bench SHALL cover: four levelCleared pulses from level 0 -> level 1, 2, 3, then bgState=11 with level held at 3.
REQ-035 Bench SHALL cover: playerHit and levelCleared in the same cycle at level 0 -> HIT_PAUSE, lives=2, level stays 0.
REQ-036 Bench SHALL cover: GAME_OVER with no key -> WELCOME after exactly 180 startOfFrame pulses; a start edge at frame 50 -> WELCOME immediately.
REQ-037 Bench SHALL cover: reset asserted during HIT_PAUSE -> bgState=00 asynchronously; with GAME_PAUSE_EN, a pause toggle freezes inPlay=0 and ignores playerHit.
